// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order write-back
// stage and one long-latency unit. The pipe normally has priority. After
// STARVE_LIMIT consecutive refused long-unit cycles, the long unit gets one
// forced grant while write-back is stalled. The register-file write command
// is registered.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data   write-back stage request
//   pipe_stall                     write-back must hold its inputs next cycle
//   lu_valid/lu_rd/lu_data         long-unit result (valid/ready handshake)
//   lu_ready                       long-unit transfer when lu_valid && lu_ready
//   rf_we/rf_waddr/rf_wdata        registered register-file write command
//
// state    | meaning
// ---------+------------------------------------------------------------
// PIPE_PRI | wait_cnt < STARVE_LIMIT, pipe wins whenever it is valid
// LONG_PRI | wait_cnt == STARVE_LIMIT, long unit forced in, pipe stalled
module wb_port_arbiter #(
  parameter int BW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_valid,
  input  logic [4:0]    pipe_rd,
  input  logic [BW-1:0] pipe_data,
  output logic          pipe_stall,
  input  logic          lu_valid,
  input  logic [4:0]    lu_rd,
  input  logic [BW-1:0] lu_data,
  output logic          lu_ready,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [BW-1:0] rf_wdata
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] wait_cnt;
  logic [2:0] wait_cnt_nxt;
  logic       long_pri;
  logic       lu_xfer;
  logic       pipe_win;

  assign long_pri = (wait_cnt == LIMIT);

  // state register
  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= '0;
    else     wait_cnt <= wait_cnt_nxt;
  end

  // next state: count refused long-unit cycles, clear on transfer or idle
  always_comb begin
    wait_cnt_nxt = '0;
    if (lu_valid && !lu_ready) begin
      if (wait_cnt >= LIMIT) wait_cnt_nxt = LIMIT;
      else                   wait_cnt_nxt = wait_cnt + 3'd1;
    end
  end

  // outputs and winner selection
  always_comb begin
    lu_ready   = 1'b0;
    pipe_stall = 1'b0;
    lu_xfer    = 1'b0;
    pipe_win   = 1'b0;
    if (!rst) begin
      if (long_pri) begin
        lu_ready   = 1'b1;
        pipe_stall = pipe_valid;
      end else begin
        lu_ready   = !pipe_valid;
      end
      lu_xfer  = lu_valid && lu_ready;
      pipe_win = pipe_valid && !long_pri;
    end
  end

  // Write command register. An x0 write completes its handshake but leaves
  // the address/data register untouched and never raises rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (lu_xfer) begin
      rf_we <= (lu_rd != 5'd0);
      if (lu_rd != 5'd0) begin
        rf_waddr <= lu_rd;
        rf_wdata <= lu_data;
      end
    end else if (pipe_win) begin
      rf_we <= (pipe_rd != 5'd0);
      if (pipe_rd != 5'd0) begin
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_data;
      end
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int BW = 32;
  localparam int LIM = 4;

  logic          clk;
  logic          rst;
  logic          pipe_valid;
  logic [4:0]    pipe_rd;
  logic [BW-1:0] pipe_data;
  logic          pipe_stall;
  logic          lu_valid;
  logic [4:0]    lu_rd;
  logic [BW-1:0] lu_data;
  logic          lu_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [BW-1:0] rf_wdata;

  int checks = 0;
  int failures = 0;

  // reference model: refused-streak counter plus the expected write command
  int            m_refused = 0;
  logic          m_we = 1'b0;
  logic [4:0]    m_waddr = '0;
  logic [BW-1:0] m_wdata = '0;
  logic          exp_ready, exp_stall;
  logic          m_lu_xfer = 1'b0;
  logic          m_stalled = 1'b0;

  wb_port_arbiter #(.BW(BW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected handshake outputs for the current inputs: once the long unit
  // has been turned away LIM times in a row it is let in unconditionally.
  function automatic void model_comb();
    bit forced;
    forced = (m_refused >= LIM);
    if (rst) begin
      exp_ready = 1'b0;
      exp_stall = 1'b0;
    end else begin
      exp_ready = forced ? 1'b1 : !pipe_valid;
      exp_stall = forced && pipe_valid;
    end
  endfunction

  function automatic void model_edge();
    bit lu_go, pipe_go;
    if (rst) begin
      m_refused = 0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_lu_xfer = 1'b0; m_stalled = 1'b0;
      return;
    end
    lu_go   = lu_valid && exp_ready;
    pipe_go = pipe_valid && !exp_stall && !lu_go;
    m_we = 1'b0;
    if (lu_go && lu_rd != 0) begin
      m_we = 1'b1; m_waddr = lu_rd; m_wdata = lu_data;
    end else if (pipe_go && pipe_rd != 0) begin
      m_we = 1'b1; m_waddr = pipe_rd; m_wdata = pipe_data;
    end
    if (lu_valid && !exp_ready) m_refused = (m_refused < LIM) ? m_refused + 1 : LIM;
    else                        m_refused = 0;
    m_lu_xfer = lu_go;
    m_stalled = exp_stall;
  endfunction

  // advance one clock: model sees the final inputs, then the edge
  task automatic step();
    model_comb();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h1111_2222;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h3333_4444;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (lu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_hs: lu_ready=%b pipe_stall=%b required 0 0", lu_ready, pipe_stall);
      end
      step();
      checks++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
        failures++;
        $display("FAIL reset_rf: we=%b waddr=%0d wdata=%h required 0 0 0", rf_we, rf_waddr, rf_wdata);
      end
    end
    rst = 1'b0; pipe_valid = 1'b0; lu_valid = 1'b0;
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_we: got %b required 0", rf_we);
    end
  endtask

  task automatic test_pipe_only();
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hffffdddd; lu_valid = 1'b0;
    #2;
    checks++;
    if (lu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      failures++;
      $display("FAIL pipe_only_hs: lu_ready=%b pipe_stall=%b required 0 0", lu_ready, pipe_stall);
    end
    step();
    pipe_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hffffdddd) begin
      failures++;
      $display("FAIL pipe_only_rf: we=%b waddr=%0d wdata=%h required 1 5 ffffdddd", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_long_only();
    pipe_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hddddffff;
    #2;
    checks++;
    if (lu_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      failures++;
      $display("FAIL long_only_hs: lu_ready=%b pipe_stall=%b required 1 0", lu_ready, pipe_stall);
    end
    step();
    lu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hddddffff) begin
      failures++;
      $display("FAIL long_only_rf: we=%b waddr=%0d wdata=%h required 1 7 ddddffff", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  // also shows the refused count started at zero after the long-only transfer
  task automatic test_starvation();
    lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'hcafe_0008;
    pipe_valid = 1'b1;
    for (int i = 0; i < LIM; i++) begin
      pipe_rd = 5'(i + 1); pipe_data = 32'h100 + 32'(i);
      #2;
      checks++;
      if (lu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
        failures++;
        $display("FAIL starve_pipe_hs[%0d]: lu_ready=%b pipe_stall=%b required 0 0", i, lu_ready, pipe_stall);
      end
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1) || rf_wdata !== 32'h100 + 32'(i)) begin
        failures++;
        $display("FAIL starve_pipe_rf[%0d]: we=%b waddr=%0d required 1 %0d", i, rf_we, rf_waddr, i + 1);
      end
    end
    pipe_rd = 5'd9; pipe_data = 32'h0000_0909;
    #2;
    checks++;
    if (lu_ready !== 1'b1 || pipe_stall !== 1'b1) begin
      failures++;
      $display("FAIL starve_forced_hs: lu_ready=%b pipe_stall=%b required 1 1", lu_ready, pipe_stall);
    end
    step();
    lu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'hcafe_0008) begin
      failures++;
      $display("FAIL starve_forced_rf: we=%b waddr=%0d wdata=%h required 1 8 cafe0008", rf_we, rf_waddr, rf_wdata);
    end
    #2;
    checks++;
    if (pipe_stall !== 1'b0) begin
      failures++;
      $display("FAIL starve_release: pipe_stall=%b required 0", pipe_stall);
    end
    step();
    pipe_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0000_0909) begin
      failures++;
      $display("FAIL starve_replay_rf: we=%b waddr=%0d wdata=%h required 1 9 00000909", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_x0();
    pipe_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hdead_beef;
    #2;
    checks++;
    if (lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_hs: lu_ready=%b required 1", lu_ready);
    end
    step();
    lu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0000_0909) begin
      failures++;
      $display("FAIL x0_rf: we=%b waddr=%0d wdata=%h required 0 9 00000909", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_reset_mid();
    lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'h0000_0c0c;
    pipe_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pipe_rd = 5'(20 + i); pipe_data = 32'(i);
      step();
    end
    rst = 1'b1;
    #2;
    checks++;
    if (lu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_hs: lu_ready=%b pipe_stall=%b required 0 0", lu_ready, pipe_stall);
    end
    step();
    rst = 1'b0;
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_rf: we=%b required 0", rf_we);
    end
    for (int i = 0; i < LIM; i++) begin
      pipe_rd = 5'(24 + i);
      #2;
      checks++;
      if (lu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_refused[%0d]: lu_ready=%b pipe_stall=%b required 0 0", i, lu_ready, pipe_stall);
      end
      step();
    end
    #2;
    checks++;
    if (lu_ready !== 1'b1 || pipe_stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_forced: lu_ready=%b pipe_stall=%b required 1 1", lu_ready, pipe_stall);
    end
    step();
    lu_valid = 1'b0; pipe_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd12) begin
      failures++;
      $display("FAIL rst_mid_grant: we=%b waddr=%0d required 1 12", rf_we, rf_waddr);
    end
    step();
  endtask

  // random traffic obeying the handshake rules, checked against the model
  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!m_stalled) begin
        pipe_valid = ($urandom_range(0, 3) != 0);
        pipe_rd    = 5'($urandom_range(0, 31));
        pipe_data  = $urandom;
      end
      if (!lu_valid || m_lu_xfer) begin
        lu_valid = ($urandom_range(0, 2) != 0);
        lu_rd    = 5'($urandom_range(0, 31));
        lu_data  = $urandom;
      end
      #2;
      model_comb();
      checks++;
      if (lu_ready !== exp_ready || pipe_stall !== exp_stall) begin
        failures++;
        $display("FAIL rand_hs[%0d]: lu_ready=%b pipe_stall=%b required %b %b", n, lu_ready, pipe_stall, exp_ready, exp_stall);
      end
      step();
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        failures++;
        $display("FAIL rand_rf[%0d]: we=%b waddr=%0d wdata=%h required %b %0d %h", n, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
    end
    rst = 1'b0; pipe_valid = 1'b0; lu_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    #1;
    test_reset();
    test_pipe_only();
    test_long_only();
    test_starvation();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port at the write-back end of the pipeline. It shares the port between the in-order write-back stage and one long-latency unit (multiply/divide or load-return) that completes out of band. The pipeline has priority, with a starvation guard that forces a long-unit grant by stalling write-back for one cycle. The register-file write command is registered, so the block sits between the write-back stage and the register file.

## Interface
Parameters:
- BW, 32, data width.
- STARVE_LIMIT, 4, consecutive refused long-unit cycles before a forced grant (1..7).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_valid  in  1  write-back stage has a register write this cycle.
- pipe_rd  in  5  destination register of the write-back stage.
- pipe_data  in  BW  write-back data (already muxed mem/ALU).
- pipe_stall  out  1  combinational; write-back stage must hold its inputs next cycle.
- lu_valid  in  1  long unit presents a result.
- lu_rd  in  5  long-unit destination register.
- lu_data  in  BW  long-unit result.
- lu_ready  out  1  combinational; a transfer occurs when lu_valid && lu_ready.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  BW  registered write data.

## Operation
- Two priority states, derived from wait_cnt (3 bits):
  - PIPE_PRI when wait_cnt < STARVE_LIMIT.
  - LONG_PRI when wait_cnt == STARVE_LIMIT.
- Winner selection in PIPE_PRI:
  - pipe_valid=1: pipe wins, lu_ready=0, pipe_stall=0.
  - pipe_valid=0: lu_ready=1; the long unit wins if lu_valid=1.
- Winner selection in LONG_PRI:
  - lu_ready=1 and the long unit wins.
  - pipe_stall=pipe_valid.
  - The pipe write is not lost; it is re-presented next cycle.
- wait_cnt update:
  - Increments (saturating at STARVE_LIMIT) when lu_valid && !lu_ready.
  - Clears to 0 on a long-unit transfer or when lu_valid=0.
  - A forced grant therefore lasts exactly one cycle, then the state returns to PIPE_PRI.
- Output register:
  - If there is a winner: rf_we <= (winner rd != 0); rf_waddr/rf_wdata <= winner rd/data.
  - If there is no winner: rf_we <= 0; rf_waddr/rf_wdata hold.
  - A write to x0 is accepted and consumed (handshake completes, stall rules unchanged) but never asserts rf_we.
- WAW ordering between the pipe and the long unit on the same rd is prevented upstream by the decode scoreboard. The arbiter performs no rd comparison.
- The long unit must hold lu_rd/lu_data stable while lu_valid=1 and no transfer has occurred. It must not drop lu_valid before a transfer.

## Timing
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, wait_cnt=0.
  - While rst=1: lu_ready=0, pipe_stall=0, and no transfer is counted.
- Latency: a grant in cycle N appears on rf_we/rf_waddr/rf_wdata after the edge ending cycle N, and is valid through cycle N+1.
- pipe_stall and lu_ready depend only on the current state and current inputs; there is no bubble between back-to-back grants.
- Throughput: one write per cycle. Sustained pipe_valid=1 with lu_valid=1 yields STARVE_LIMIT pipe writes, then 1 forced long write, repeating.
- Simultaneous rst and valid inputs: reset wins, nothing is written, and wait_cnt=0 on the following cycle.
- Reset mid-stall: the pending long result is re-arbitrated from wait_cnt=0 after reset deasserts.

## Test plan
- Pipe only:
  - Stimulus: pipe_valid=1, rd=5, data=32'hffffdddd at cycle N.
  - Required: rf_we=1, waddr=5, wdata=32'hffffdddd in N+1; lu_ready=0; pipe_stall=0 throughout.
- Long unit only:
  - Stimulus: lu_valid=1, rd=7, data=32'hddddffff with pipe_valid=0.
  - Required: lu_ready=1 the same cycle; rf_we=1, waddr=7 next cycle; wait_cnt stays 0.
- Starvation guard:
  - Stimulus: pipe_valid=1 with rd=1,2,3,4,9 on consecutive cycles; lu_valid=1, rd=8 throughout.
  - Required: pipe writes rd 1..4 land; cycle 5 has lu_ready=1 and pipe_stall=1; rf_waddr=8 next; rd 9 lands the cycle after.
- x0 suppression:
  - Stimulus: lu_valid=1, lu_rd=0 with pipe idle.
  - Required: transfer completes (lu_ready=1); rf_we stays 0; rf_waddr/rf_wdata unchanged.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle when wait_cnt=3 with both requesters active.
  - Required: rf_we=0, lu_ready=0, pipe_stall=0 during reset; the forced grant occurs only after 4 further refused cycles.
